// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM encodings and handshake constants for the multi-cycle divider
package div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - EX-to-divider request/result bundle; optional div_by_zero_o under DIV_ZERO_FLAG_EN
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_by_zero_o;
`endif

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
        input  div_by_zero_o,
`endif
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
        output div_by_zero_o,
`endif
        output result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// rtl/div.sv - radix-2 restoring DIV/DIVU, one quotient bit per clock; DIV_ZERO_FLAG_EN adds div_by_zero_o
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*DATA_W:0]       r_dividend;
    logic [DATA_W-1:0]       r_divisor;
    logic                    r_neg_quo;
    logic                    r_neg_rem;
    logic [2*DATA_W-1:0]     r_result;
    logic                    r_ready;

    logic [DATA_W:0]         w_t;
    logic [DATA_W-1:0]       w_op1_abs;
    logic [DATA_W-1:0]       w_op2_abs;
    logic [DATA_W-1:0]       w_quo;
    logic [DATA_W-1:0]       w_rem;
    logic                    w_op1_neg;
    logic                    w_op2_neg;

    assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign w_op1_abs = w_op1_neg ? ({DATA_W{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
    assign w_op2_abs = w_op2_neg ? ({DATA_W{1'b0}} - bus.opdata2_i) : bus.opdata2_i;

    // Trial subtract; the extra top bit is the borrow that rejects the step.
    assign w_t = {1'b0, r_dividend[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};

    assign w_quo = r_neg_quo ? ({DATA_W{1'b0}} - r_dividend[DATA_W-1:0])
                             : r_dividend[DATA_W-1:0];
    assign w_rem = r_neg_rem ? ({DATA_W{1'b0}} - r_dividend[2*DATA_W:DATA_W+1])
                             : r_dividend[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
            r_ready    <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                    if (bus.start_i == DIV_START && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state    <= DIV_ON;
                            r_cnt      <= '0;
                            r_dividend <= {{DATA_W{1'b0}}, w_op1_abs, 1'b0};
                            r_divisor  <= w_op2_abs;
                            r_neg_quo  <= w_op1_neg ^ w_op2_neg;
                            r_neg_rem  <= w_op1_neg;
                        end
                    end
                end
                DIV_BYZERO: begin
                    r_state  <= DIV_END;
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (bus.annul_i) begin
                        r_state  <= DIV_FREE;
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                    end else if (r_cnt != CNT_W'(DATA_W)) begin
                        if (w_t[DATA_W]) begin
                            r_dividend <= {r_dividend[2*DATA_W-1:0], 1'b0};
                        end else begin
                            r_dividend <= {w_t[DATA_W-1:0], r_dividend[DATA_W-1:0], 1'b1};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state  <= DIV_END;
                        r_result <= {w_rem, w_quo};
                        r_ready  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (bus.start_i == DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

`ifdef DIV_ZERO_FLAG_EN
    logic r_div_by_zero;

    // Rises together with ready_o on the zero-divisor path, drops when END is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_by_zero <= 1'b0;
        end else if (r_state == DIV_BYZERO) begin
            r_div_by_zero <= 1'b1;
        end else if (r_state == DIV_END && bus.start_i == DIV_STOP) begin
            r_div_by_zero <= 1'b0;
        end
    end

    assign bus.div_by_zero_o = r_div_by_zero;
`else
    // Without the flag a zero divisor shows only as a zero result with short latency.
`endif

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div: vector table, corner sequences, randomized model check
module tb_div;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_if #(.DATA_W(32)) bus ();

    div #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", nm, act, exp);
    endtask

    // Quotient truncates toward zero, remainder takes the dividend's sign; 64-bit math avoids overflow.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts a division, scrambles the operands after the sampling edge, waits for ready.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        lat = -1;
        @(posedge clk);
        @(negedge clk);
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) begin
                lat = k;
                break;
            end
        end
        res = bus.result_o;
    endtask

    task automatic stop_div(input bit check);
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk("drop_ready", 64'(bus.ready_o), 64'd0);
            chk("drop_result", bus.result_o, 64'd0);
        end
    endtask

    logic [63:0] res, exp, held;
    int          lat, seen;
    bit          rs;
    logic [31:0] ra, rb;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
        vecs[3] = '{1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 1};
        vecs[4] = '{1'b1, 32'hFFFFFFFB,   32'd0,        64'h00000000_00000000, 1};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF, 33};
        vecs[6] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
        vecs[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33};
        vecs[9] = '{1'b0, 32'd3,          32'd9,        64'h00000003_00000000, 33};

        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
`ifdef DIV_ZERO_FLAG_EN
            chk($sformatf("vec%0d_dbz", i), 64'(bus.div_by_zero_o), 64'(vecs[i].b == 32'd0));
`endif
            stop_div(i < 2 || i == 3);
`ifdef DIV_ZERO_FLAG_EN
            if (i == 3) chk("dbz_cleared", 64'(bus.div_by_zero_o), 64'd0);
`endif
        end

        // Annul after ten iterations, then a fresh division must still work.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, res, lat);
        chk("after_annul_result", res, 64'h0000000F_0FFFFFFF);
        chk("after_annul_latency", 64'(lat), 64'd33);
        stop_div(1'b0);

        // Reset in the middle of ON.
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o) seen++;
        end
        chk("rst_on_no_ready", 64'(seen), 64'd0);

        // Reset while holding a result in END.
        run_div(1'b0, 32'd100, 32'd7, res, lat);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_end_result", bus.result_o, 64'd0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, res, lat);
        chk("after_rst_result", res, 64'hFFFFFFFF_FFFFFFFD);
        stop_div(1'b0);

        // Hold start in END: the overflow result must stay put.
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, held, lat);
        chk("hold_first", held, 64'h00000000_80000000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_result%0d", k), bus.result_o, 64'h00000000_80000000);
            chk($sformatf("hold_ready%0d", k), 64'(bus.ready_o), 64'd1);
        end
        stop_div(1'b1);

        for (int n = 0; n < 50; n++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom % 4)
                0: rb = $urandom;
                1: rb = $urandom % 16;
                2: rb = $urandom >> ($urandom % 32);
                default: rb = 32'hFFFFFFFF - ($urandom % 4);
            endcase
            exp = model(rs, ra, rb);
            run_div(rs, ra, rb, res, lat);
            chk($sformatf("rand%0d s=%0d %h/%h", n, rs, ra, rb), res, exp);
            chk($sformatf("rand%0d_latency", n), 64'(lat), (rb == 32'd0) ? 64'd1 : 64'd33);
            stop_div(1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
